// File: rtl/reg_file_pkg.sv
// Shared definitions for the multi-port register file.
//   DefaultDataW / DefaultAddrW : default word and address widths
//   reg_file_state_e            : StClear (zero sweep in progress), StReady (accesses accepted)
package reg_file_pkg;

   localparam int unsigned DefaultDataW = 32;
   localparam int unsigned DefaultAddrW = 4;

   typedef enum logic {
      StClear = 1'b0,
      StReady = 1'b1
   } reg_file_state_e;

endpackage

// File: rtl/reg_file_bmerge.sv
// Combinational byte merge: bytes of new_word whose be bit is set replace the
// corresponding bytes of old_word. Shared by the write path and the read bypass.
//   old_word : current storage contents
//   new_word : incoming write data
//   be       : byte enables, bit i covers bits 8i+7:8i
//   merged   : resulting word
module reg_file_bmerge
   import reg_file_pkg::*;
#(
   parameter int unsigned DATA_W = DefaultDataW
) (
   input  logic [DATA_W-1:0]   old_word,
   input  logic [DATA_W-1:0]   new_word,
   input  logic [DATA_W/8-1:0] be,
   output logic [DATA_W-1:0]   merged
);

   always_comb begin
      merged = old_word;
      for (int i = 0; i < int'(DATA_W / 8); i++) begin
         if (be[i]) begin
            merged[8*i +: 8] = new_word[8*i +: 8];
         end
      end
   end

endmodule

// File: rtl/reg_file_mp.sv
// Register file with one byte-enabled write port and two registered read ports.
// After reset the storage is swept to zero one entry per cycle; accesses are only
// accepted once ready is high, and requests made during the sweep raise err.
//   clk, rst_n            : clock, synchronous active-low reset
//   ready, err            : sweep done / access-during-sweep pulse
//   wr_en/addr/be/data    : write port
//   rdN_en/addr           : read requests (N = 0, 1)
//   rdN_data/valid        : read result, one cycle after the request
// Build option: define REG_FILE_MP_BYPASS_EN to make a same-cycle read of the
// write address return the newly merged word instead of the old contents.
module reg_file_mp
   import reg_file_pkg::*;
#(
   parameter int unsigned DATA_W = DefaultDataW,
   parameter int unsigned ADDR_W = DefaultAddrW
) (
   input  logic                clk,
   input  logic                rst_n,
   output logic                ready,
   output logic                err,
   input  logic                wr_en,
   input  logic [ADDR_W-1:0]   wr_addr,
   input  logic [DATA_W/8-1:0] wr_be,
   input  logic [DATA_W-1:0]   wr_data,
   input  logic                rd0_en,
   input  logic [ADDR_W-1:0]   rd0_addr,
   output logic [DATA_W-1:0]   rd0_data,
   output logic                rd0_valid,
   input  logic                rd1_en,
   input  logic [ADDR_W-1:0]   rd1_addr,
   output logic [DATA_W-1:0]   rd1_data,
   output logic                rd1_valid
);

   localparam int unsigned Depth = 2 ** ADDR_W;

   logic [DATA_W-1:0] mem [Depth];

   reg_file_state_e   state_q, state_d;
   logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
   logic              err_q, err_d;

   logic              wr_fire;
   logic [DATA_W-1:0] wr_word;

   // Read ports folded into arrays so both are built from the same logic.
   logic              rd_en   [2];
   logic [ADDR_W-1:0] rd_addr [2];
   logic [DATA_W-1:0] rd_data [2];
   logic              rd_valid[2];

   assign rd_en[0]   = rd0_en;
   assign rd_en[1]   = rd1_en;
   assign rd_addr[0] = rd0_addr;
   assign rd_addr[1] = rd1_addr;
   assign rd0_data   = rd_data[0];
   assign rd1_data   = rd_data[1];
   assign rd0_valid  = rd_valid[0];
   assign rd1_valid  = rd_valid[1];

   assign ready   = (state_q == StReady);
   assign err     = err_q;
   assign wr_fire = wr_en && (state_q == StReady);

   // Merged word for mem[wr_addr]; also the bypass value for a matching read.
   reg_file_bmerge #(
      .DATA_W(DATA_W)
   ) u_bmerge (
      .old_word(mem[wr_addr]),
      .new_word(wr_data),
      .be      (wr_be),
      .merged  (wr_word)
   );

   always_comb begin
      state_d   = state_q;
      clr_ptr_d = clr_ptr_q;
      err_d     = 1'b0;
      unique case (state_q)
         StClear: begin
            clr_ptr_d = clr_ptr_q + 1'b1;
            err_d     = wr_en | rd0_en | rd1_en;
            if (clr_ptr_q == {ADDR_W{1'b1}}) begin
               state_d = StReady;
            end
         end
         StReady: begin
            // Only reset leaves this state.
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= StClear;
         clr_ptr_q <= '0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         clr_ptr_q <= clr_ptr_d;
         err_q     <= err_d;
      end
   end

   // Storage has no reset; it is zeroed only by the sweep.
   always_ff @(posedge clk) begin
      if (rst_n) begin
         if (state_q == StClear) begin
            mem[clr_ptr_q] <= '0;
         end else if (wr_fire) begin
            mem[wr_addr] <= wr_word;
         end
      end
   end

   for (genvar p = 0; p < 2; p++) begin : g_rd
      logic              fire;
      logic [DATA_W-1:0] word;
      logic [DATA_W-1:0] data_q;
      logic              valid_q;

      assign fire = rd_en[p] && (state_q == StReady);

`ifdef REG_FILE_MP_BYPASS_EN
      assign word = (wr_fire && (rd_addr[p] == wr_addr)) ? wr_word : mem[rd_addr[p]];
`else
      assign word = mem[rd_addr[p]];
`endif

      always_ff @(posedge clk) begin
         if (!rst_n) begin
            data_q  <= '0;
            valid_q <= 1'b0;
         end else begin
            valid_q <= fire;
            if (fire) begin
               data_q <= word;
            end
         end
      end

      assign rd_data[p]  = data_q;
      assign rd_valid[p] = valid_q;
   end

endmodule

// File: tb/tb_reg_file_mp.sv
// Randomised bench for reg_file_mp with a behavioural model and directed scenarios.
module tb_reg_file_mp;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        ready, err;
   logic        wr_en;
   logic [3:0]  wr_addr;
   logic [3:0]  wr_be;
   logic [31:0] wr_data;
   logic        rd0_en, rd1_en;
   logic [3:0]  rd0_addr, rd1_addr;
   logic [31:0] rd0_data, rd1_data;
   logic        rd0_valid, rd1_valid;

   always #5 clk = ~clk;

   reg_file_mp dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .ready    (ready),
      .err      (err),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .wr_be    (wr_be),
      .wr_data  (wr_data),
      .rd0_en   (rd0_en),
      .rd0_addr (rd0_addr),
      .rd0_data (rd0_data),
      .rd0_valid(rd0_valid),
      .rd1_en   (rd1_en),
      .rd1_addr (rd1_addr),
      .rd1_data (rd1_data),
      .rd1_valid(rd1_valid)
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", tag, got, exp);
   endtask

   // Behavioural model: "rel" counts clock edges with rst_n high since the last
   // reset; the first 16 of them clear entry rel, after that the file is ready.
   logic [31:0] mem_m [16];
   int          rel = 0;
   logic        e_ready = 1'b0, e_err = 1'b0, e_v0 = 1'b0, e_v1 = 1'b0;
   logic [31:0] e_d0 = '0, e_d1 = '0;

   function automatic logic [31:0] merge_m(input logic [31:0] old_w, input logic [31:0] new_w,
                                           input logic [3:0] be);
      logic [31:0] r;
      r = old_w;
      for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = new_w[8*i +: 8];
      return r;
   endfunction

   function automatic logic [31:0] read_m(input logic [3:0] a);
`ifdef REG_FILE_MP_BYPASS_EN
      if (wr_en && a == wr_addr) return merge_m(mem_m[a], wr_data, wr_be);
`endif
      return mem_m[a];
   endfunction

   task automatic model_edge();
      if (!rst_n) begin
         rel = 0; e_ready = 1'b0; e_err = 1'b0;
         e_v0 = 1'b0; e_v1 = 1'b0; e_d0 = '0; e_d1 = '0;
      end else if (rel < 16) begin
         mem_m[rel] = '0;
         e_err = wr_en | rd0_en | rd1_en;
         e_v0 = 1'b0; e_v1 = 1'b0;
         rel++;
         e_ready = (rel >= 16);
      end else begin
         e_err = 1'b0;
         e_v0 = rd0_en; e_v1 = rd1_en;
         if (rd0_en) e_d0 = read_m(rd0_addr);
         if (rd1_en) e_d1 = read_m(rd1_addr);
         if (wr_en) mem_m[wr_addr] = merge_m(mem_m[wr_addr], wr_data, wr_be);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      model_edge();
      #1;
      check("ready", 32'(ready), 32'(e_ready));
      check("err", 32'(err), 32'(e_err));
      check("rd0_valid", 32'(rd0_valid), 32'(e_v0));
      check("rd1_valid", 32'(rd1_valid), 32'(e_v1));
      check("rd0_data", rd0_data, e_d0);
      check("rd1_data", rd1_data, e_d1);
   endtask

   task automatic idle();
      wr_en = 1'b0; rd0_en = 1'b0; rd1_en = 1'b0;
   endtask

   task automatic wr(input logic [3:0] a, input logic [3:0] be, input logic [31:0] d);
      wr_en = 1'b1; wr_addr = a; wr_be = be; wr_data = d;
      cyc();
      idle();
   endtask

   task automatic rd2(input logic [3:0] a0, input logic [3:0] a1);
      rd0_en = 1'b1; rd0_addr = a0; rd1_en = 1'b1; rd1_addr = a1;
      cyc();
      idle();
   endtask

   initial begin
      rst_n = 1'b0;
      idle();
      wr_addr = '0; wr_be = '0; wr_data = '0; rd0_addr = '0; rd1_addr = '0;

      // Reset then idle sweep
      cyc(); cyc();
      check("rst_ready", 32'(ready), 32'd0);
      rst_n = 1'b1;
      for (int i = 0; i < 15; i++) begin
         cyc();
         check("clr_ready", 32'(ready), 32'd0);
      end
      cyc();
      check("ready_up", 32'(ready), 32'd1);
      for (int a = 0; a < 16; a++) begin
         rd2(4'(a), 4'(15 - a));
         check("init0", rd0_data, 32'h0);
         check("init1", rd1_data, 32'h0);
      end

      // Byte enables
      wr(4'd3, 4'hF, 32'hAABBCCDD);
      wr(4'd3, 4'h5, 32'h11223344);
      rd0_en = 1'b1; rd0_addr = 4'd3;
      cyc();
      idle();
      check("be_valid", 32'(rd0_valid), 32'd1);
      check("be_data", rd0_data, 32'hAA22CC44);
      cyc();
      check("be_valid_drop", 32'(rd0_valid), 32'd0);
      check("be_hold", rd0_data, 32'hAA22CC44);

      // Dual read
      wr(4'd5, 4'hF, 32'h12345678);
      wr(4'd9, 4'hF, 32'h9ABCDEF0);
      rd2(4'd5, 4'd9);
      check("dual0", rd0_data, 32'h12345678);
      check("dual1", rd1_data, 32'h9ABCDEF0);
      rd2(4'd5, 4'd5);
      check("same0", rd0_data, 32'h12345678);
      check("same1", rd1_data, 32'h12345678);

      // Read during write
      wr_en = 1'b1; wr_addr = 4'd7; wr_be = 4'hF; wr_data = 32'hDEADBEEF;
      rd0_en = 1'b1; rd0_addr = 4'd7;
      cyc();
      idle();
`ifdef REG_FILE_MP_BYPASS_EN
      check("rdw", rd0_data, 32'hDEADBEEF);
`else
      check("rdw", rd0_data, 32'h00000000);
`endif
      rd2(4'd7, 4'd7);
      check("rdw_next", rd0_data, 32'hDEADBEEF);

      // Reset mid-operation, with an access during the new sweep
      wr(4'd1, 4'hF, 32'h00000055);
      rst_n = 1'b0;
      cyc();
      check("midrst_ready", 32'(ready), 32'd0);
      rst_n = 1'b1;
      cyc(); cyc(); cyc();
      wr_en = 1'b1; wr_addr = 4'd2; wr_be = 4'hF; wr_data = 32'hFFFFFFFF;
      cyc();
      idle();
      check("clr_err", 32'(err), 32'd1);
      check("clr_novalid", 32'(rd0_valid), 32'd0);
      cyc();
      check("clr_err_once", 32'(err), 32'd0);
      for (int i = 0; i < 10; i++) begin
         cyc();
         check("resweep_ready", 32'(ready), 32'd0);
      end
      cyc();
      check("resweep_up", 32'(ready), 32'd1);
      rd2(4'd1, 4'd2);
      check("midrst_a1", rd0_data, 32'h0);
      check("clr_a2", rd1_data, 32'h0);

      // Random traffic with occasional resets
      for (int n = 0; n < 3000; n++) begin
         rst_n    = ($urandom_range(0, 299) != 0);
         wr_en    = $urandom_range(0, 1) == 1;
         wr_addr  = 4'($urandom_range(0, 15));
         wr_be    = 4'($urandom_range(0, 15));
         wr_data  = $urandom;
         rd0_en   = $urandom_range(0, 1) == 1;
         rd0_addr = 4'($urandom_range(0, 15));
         rd1_en   = $urandom_range(0, 1) == 1;
         rd1_addr = ($urandom_range(0, 3) == 0) ? wr_addr : 4'($urandom_range(0, 15));
         cyc();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/reg_file_mp.md
REG_FILE_MP -- requirements
Module: reg_file_mp

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning word width in bits; must be a multiple of 8.
REQ-002 SHALL have parameter ADDR_W, default 4, meaning address width; DEPTH = 2**ADDR_W entries (default 16).
REQ-003 SHALL have port clk  input  1  the single clock; all logic on posedge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port ready  output  1  high when the initial clear is complete and accesses are accepted.
REQ-006 SHALL have port err  output  1  one-cycle pulse when an access is requested while ready is low.
REQ-007 SHALL have port wr_en  input  1  write request.
REQ-008 SHALL have port wr_addr  input  ADDR_W  write address.
REQ-009 SHALL have port wr_be  input  DATA_W/8  byte enables; bit i covers data bits 8i+7:8i.
REQ-010 SHALL have port wr_data  input  DATA_W  write data.
REQ-011 SHALL have ports rd0_en / rd1_en  input  1  read requests, ports 0 and 1.
REQ-012 SHALL have ports rd0_addr / rd1_addr  input  ADDR_W  read addresses.
REQ-013 SHALL have ports rd0_data / rd1_data  output  DATA_W  registered read data.
REQ-014 SHALL have ports rd0_valid / rd1_valid  output  1  high for the cycle in which rdN_data is valid.

Function
REQ-015 SHALL implement a two-state FSM: CLEAR (sweeping storage to zero) and READY.
REQ-016 In CLEAR, SHALL write zero to entry clr_ptr each cycle and increment clr_ptr, starting at 0.
REQ-017 SHALL move CLEAR->READY on the cycle entry DEPTH-1 is cleared; ready SHALL be 1 from the next cycle, i.e. DEPTH cycles after the first cycle with rst_n high.
REQ-018 READY SHALL be left only by reset.
REQ-019 In READY, wr_en SHALL update only the bytes of mem[wr_addr] whose wr_be bit is 1; wr_be all-zero SHALL leave memory unchanged.
REQ-020 In READY, rdN_en SHALL produce rdN_data = mem[rdN_addr] and rdN_valid = 1 exactly one cycle later (latency 1).
REQ-021 When rdN_en is 0, rdN_valid SHALL be 0 next cycle, and rdN_data SHALL hold its last value.
REQ-022 Both read ports and the write port SHALL operate independently in the same cycle, including identical addresses.
REQ-023 Read-during-write to the same address SHALL follow REQ-033/REQ-034.
REQ-024 In CLEAR, SHALL ignore wr_en and rdN_en, keep rdN_valid 0, and pulse err the next cycle if any of wr_en, rd0_en, rd1_en is 1.
REQ-025 Address wrap SHALL not occur: every ADDR_W value is a valid entry.

Reset
REQ-026 While rst_n is 0 at posedge: ready=0, err=0, rd0_valid=rd1_valid=0, rd0_data=rd1_data=0, clr_ptr=0, state=CLEAR.
REQ-027 Reset asserted mid-clear or during READY SHALL restart the full clear sweep; no partial contents survive.
REQ-028 Storage SHALL not be reset directly; it is zeroed only by the sweep.

Configuration
REQ-029 Macro REG_FILE_MP_BYPASS_EN SHALL select read-during-write behaviour.
REQ-033 With REG_FILE_MP_BYPASS_EN defined: same-cycle read of wr_addr SHALL return the merged new word (enabled bytes from wr_data, others from memory).
REQ-034 Without it: same-cycle read of wr_addr SHALL return the pre-write contents; new data visible from the next read.

Structure
REQ-030 SHALL place the FSM state enum (CLEAR, READY) and default DATA_W/ADDR_W constants in shared package reg_file_pkg.
REQ-031 SHALL use one sub-module, reg_file_bmerge, the combinational byte-merge of old word, wr_data and wr_be, reused for write and bypass.
REQ-032 Read ports SHALL be instantiated as identical logic, no port priority.

Verification
REQ-035 Reset then idle: rst_n low 2 cycles, release -> ready=0 for 16 cycles, ready=1 on cycle 17; read all 16 addrs -> all 0x00000000.
REQ-036 Byte enables: write 0xAABBCCDD be=0xF to addr 3, then 0x11223344 be=0x5 -> read addr 3 = 0xAA22CC44, rd0_valid one cycle after rd0_en.
REQ-037 Dual read: addr 5=0x12345678, addr 9=0x9ABCDEF0; rd0 addr 5 and rd1 addr 9 same cycle -> both correct next cycle; both ports addr 5 -> both 0x12345678.
REQ-038 Read-during-write: addr 7 holds 0x0; write 0xDEADBEEF be=0xF and read addr 7 same cycle -> 0xDEADBEEF with BYPASS_EN, 0x00000000 without; next read 0xDEADBEEF in both builds.
REQ-039 Access during clear: wr_en=1 addr 2 data 0xFFFFFFFF on cycle 4 after release -> err pulses once, no rd_valid; after ready, addr 2 reads 0x0.
REQ-040 Reset mid-operation: write addr 1=0x55, assert rst_n low 1 cycle -> ready drops, 16-cycle sweep repeats, addr 1 reads 0x0.
